// File: rtl/cr_huf_comp_htb_sched.sv
// Dispatches tree-build jobs to two builder pipes and releases finished trees
// to the writer strictly in acceptance order, flagging builder protocol errors.
module cr_huf_comp_htb_sched #(
  parameter int ORDER_DEPTH = 4,
  parameter int SEQID_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sw_disable_second_pipe,
  input  logic                           job_valid,
  input  logic [SEQID_W-1:0]             job_seq_id,
  output logic                           job_ready,
  input  logic                           p1_not_ready,
  input  logic                           p2_not_ready,
  output logic                           p1_start,
  output logic                           p2_start,
  output logic [SEQID_W-1:0]             start_seq_id,
  input  logic                           p1_done,
  input  logic                           p2_done,
  input  logic [SEQID_W-1:0]             p1_done_seq_id,
  input  logic [SEQID_W-1:0]             p2_done_seq_id,
  output logic                           out_valid,
  output logic [1:0]                     out_grant,
  output logic [SEQID_W-1:0]             out_seq_id,
  input  logic                           out_rd_done,
  output logic [$clog2(ORDER_DEPTH):0]   occupancy,
  output logic                           err_protocol
);
  localparam int AW = $clog2(ORDER_DEPTH);
  localparam int OW = AW + 1;

  logic               busy1_q, busy1_d, busy2_q, busy2_d;
  logic [SEQID_W-1:0] inflight1_q, inflight1_d, inflight2_q, inflight2_d;
  logic [1:0]         cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic               p1_start_q, p1_start_d, p2_start_q, p2_start_d;
  logic [SEQID_W-1:0] start_seq_q, start_seq_d;
  logic               err_q, err_d;
  // Pipe tag per entry: 0 = pipe 1, 1 = pipe 2.
  logic               fifo_pipe_q [ORDER_DEPTH];
  logic [SEQID_W-1:0] fifo_seq_q  [ORDER_DEPTH];

  logic avail1, avail2, full, accept, sel2, head_pipe, pop, dec1, dec2;
  logic [1:0] head_cnt;

  assign avail1    = !busy1_q && !p1_not_ready;
  assign avail2    = !busy2_q && !p2_not_ready && !sw_disable_second_pipe;
  assign full      = (occ_q == OW'(ORDER_DEPTH));
  assign job_ready = !rst && !full && (avail1 || avail2);
  assign accept    = job_valid && job_ready;
  assign sel2      = !avail1;

  assign head_pipe    = fifo_pipe_q[rd_ptr_q];
  assign head_cnt     = head_pipe ? cnt2_q : cnt1_q;
  assign out_valid    = (occ_q != '0) && (head_cnt != 2'd0);
  assign out_grant    = out_valid ? (head_pipe ? 2'b10 : 2'b01) : 2'b00;
  assign out_seq_id   = out_valid ? fifo_seq_q[rd_ptr_q] : '0;
  assign pop          = out_rd_done && out_valid;
  assign dec1         = pop && !head_pipe;
  assign dec2         = pop && head_pipe;

  assign occupancy    = occ_q;
  assign p1_start     = p1_start_q;
  assign p2_start     = p2_start_q;
  assign start_seq_id = start_seq_q;
  assign err_protocol = err_q;

  always_comb begin
    busy1_d     = busy1_q;
    busy2_d     = busy2_q;
    inflight1_d = inflight1_q;
    inflight2_d = inflight2_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q + OW'(accept) - OW'(pop);
    p1_start_d  = accept && !sel2;
    p2_start_d  = accept && sel2;
    start_seq_d = accept ? job_seq_id : start_seq_q;
    err_d       = err_q;

    if (p1_done) busy1_d = 1'b0;
    if (p2_done) busy2_d = 1'b0;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (sel2) begin
        busy2_d     = 1'b1;
        inflight2_d = job_seq_id;
      end else begin
        busy1_d     = 1'b1;
        inflight1_d = job_seq_id;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // A done and a read-out on the same pipe cancel; increments saturate at 3.
    if (p1_done && !dec1)      cnt1_d = (cnt1_q == 2'd3) ? 2'd3 : cnt1_q + 2'd1;
    else if (dec1 && !p1_done) cnt1_d = cnt1_q - 2'd1;
    if (p2_done && !dec2)      cnt2_d = (cnt2_q == 2'd3) ? 2'd3 : cnt2_q + 2'd1;
    else if (dec2 && !p2_done) cnt2_d = cnt2_q - 2'd1;

    if (p1_done && (!busy1_q || p1_done_seq_id != inflight1_q || cnt1_q == 2'd3)) err_d = 1'b1;
    if (p2_done && (!busy2_q || p2_done_seq_id != inflight2_q || cnt2_q == 2'd3)) err_d = 1'b1;
    if (out_rd_done && !out_valid) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy1_q     <= 1'b0;
      busy2_q     <= 1'b0;
      inflight1_q <= '0;
      inflight2_q <= '0;
      cnt1_q      <= 2'd0;
      cnt2_q      <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      p1_start_q  <= 1'b0;
      p2_start_q  <= 1'b0;
      start_seq_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < ORDER_DEPTH; i++) begin
        fifo_pipe_q[i] <= 1'b0;
        fifo_seq_q[i]  <= '0;
      end
    end else begin
      busy1_q     <= busy1_d;
      busy2_q     <= busy2_d;
      inflight1_q <= inflight1_d;
      inflight2_q <= inflight2_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      p1_start_q  <= p1_start_d;
      p2_start_q  <= p2_start_d;
      start_seq_q <= start_seq_d;
      err_q       <= err_d;
      if (accept) begin
        fifo_pipe_q[wr_ptr_q] <= sel2;
        fifo_seq_q[wr_ptr_q]  <= job_seq_id;
      end
    end
  end
endmodule

// File: tb/tb_cr_huf_comp_htb_sched.sv
// Directed bench for the Huffman tree-builder scheduler; grant order is
// checked against a queue of expected {grant, seq_id} filled at accept time.
module tb_cr_huf_comp_htb_sched;
  localparam int DEPTH = 4;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst, sw_dis, job_valid, p1_nr, p2_nr, p1_done, p2_done, out_rd_done;
  logic [SW-1:0] job_seq_id, p1_dseq, p2_dseq;
  logic          job_ready, p1_start, p2_start, out_valid, err_protocol;
  logic [SW-1:0] start_seq_id, out_seq_id;
  logic [1:0]    out_grant;
  logic [2:0]    occupancy;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  cr_huf_comp_htb_sched #(.ORDER_DEPTH(DEPTH), .SEQID_W(SW)) dut (
    .clk(clk), .rst(rst), .sw_disable_second_pipe(sw_dis),
    .job_valid(job_valid), .job_seq_id(job_seq_id), .job_ready(job_ready),
    .p1_not_ready(p1_nr), .p2_not_ready(p2_nr),
    .p1_start(p1_start), .p2_start(p2_start), .start_seq_id(start_seq_id),
    .p1_done(p1_done), .p2_done(p2_done),
    .p1_done_seq_id(p1_dseq), .p2_done_seq_id(p2_dseq),
    .out_valid(out_valid), .out_grant(out_grant), .out_seq_id(out_seq_id),
    .out_rd_done(out_rd_done), .occupancy(occupancy), .err_protocol(err_protocol)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [SW-1:0] seq, input int pipe);
    job_valid = 1'b1;
    job_seq_id = seq;
    settle();
    chk("acc_ready", job_ready, 1);
    step();
    job_valid = 1'b0;
    chk("acc_p1_start", p1_start, (pipe == 1));
    chk("acc_p2_start", p2_start, (pipe == 2));
    chk("acc_start_seq", start_seq_id, seq);
    exp_q.push_back({(pipe == 1) ? 2'b01 : 2'b10, seq});
  endtask

  task automatic done(input int pipe, input logic [SW-1:0] seq);
    if (pipe == 1) begin p1_done = 1'b1; p1_dseq = seq; end
    else begin p2_done = 1'b1; p2_dseq = seq; end
    step();
    p1_done = 1'b0;
    p2_done = 1'b0;
  endtask

  task automatic check_head();
    logic [5:0] e;
    settle();
    chk("rd_valid", out_valid, 1);
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL rd_scoreboard: observed=empty expected=entry");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_grant", out_grant, e[5:4]);
      chk("rd_seq", out_seq_id, e[3:0]);
    end
  endtask

  task automatic readout();
    check_head();
    out_rd_done = 1'b1;
    step();
    out_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1; sw_dis = 1'b0; job_valid = 1'b0; job_seq_id = '0;
    p1_nr = 1'b0; p2_nr = 1'b0; p1_done = 1'b0; p2_done = 1'b0;
    p1_dseq = '0; p2_dseq = '0; out_rd_done = 1'b0;
    step(); step(); step();
    settle();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_grant", out_grant, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_protocol, 0);
    chk("rst_p1_start", p1_start, 0);
    chk("rst_start_seq", start_seq_id, 0);
    rst = 1'b0;
    settle();
    chk("idle_job_ready", job_ready, 1);

    // Single job
    accept(4'd5, 1);
    settle();
    chk("single_wait_valid", out_valid, 0);
    done(1, 4'd5);
    readout();
    settle();
    chk("single_occ", occupancy, 0);
    chk("single_valid_after", out_valid, 0);

    // Reorder: pipe 2 finishes first
    accept(4'd1, 1);
    accept(4'd2, 2);
    chk("reorder_occ", occupancy, 2);
    done(2, 4'd2);
    settle();
    chk("reorder_hold", out_valid, 0);
    done(1, 4'd1);
    readout();
    readout();
    settle();
    chk("reorder_err", err_protocol, 0);

    // Second pipe disabled
    sw_dis = 1'b1;
    accept(4'd3, 1);
    job_valid = 1'b1;
    job_seq_id = 4'd4;
    settle();
    chk("dis_ready", job_ready, 0);
    step();
    chk("dis_no_p2", p2_start, 0);
    chk("dis_no_p1", p1_start, 0);
    done(1, 4'd3);
    settle();
    chk("dis_release_ready", job_ready, 1);
    step();
    job_valid = 1'b0;
    chk("dis_p1_start", p1_start, 1);
    chk("dis_p2_start", p2_start, 0);
    chk("dis_start_seq", start_seq_id, 4'd4);
    exp_q.push_back({2'b01, 4'd4});
    readout();
    done(1, 4'd4);
    readout();
    sw_dis = 1'b0;

    // Fill the order FIFO
    accept(4'd6, 1);
    accept(4'd7, 2);
    done(1, 4'd6);
    accept(4'd8, 1);
    done(2, 4'd7);
    accept(4'd9, 2);
    chk("full_occ", occupancy, DEPTH);
    done(1, 4'd8);
    settle();
    chk("full_ready", job_ready, 0);
    readout();
    settle();
    chk("full_occ_after", occupancy, 3);
    chk("full_ready_after", job_ready, 1);
    // accept and pop together keep occupancy constant
    check_head();
    job_valid = 1'b1; job_seq_id = 4'd14; out_rd_done = 1'b1;
    step();
    job_valid = 1'b0; out_rd_done = 1'b0;
    chk("accpop_p1_start", p1_start, 1);
    exp_q.push_back({2'b01, 4'd14});
    settle();
    chk("accpop_occ", occupancy, 3);
    readout();
    done(2, 4'd9);
    readout();
    done(1, 4'd14);
    readout();
    settle();
    chk("drain_occ", occupancy, 0);

    // Done and read-out on pipe 1 in the same cycle
    accept(4'd10, 1);
    done(1, 4'd10);
    accept(4'd11, 1);
    check_head();
    p1_done = 1'b1; p1_dseq = 4'd11; out_rd_done = 1'b1;
    step();
    p1_done = 1'b0; out_rd_done = 1'b0;
    settle();
    chk("simul_valid", out_valid, 1);
    readout();
    settle();
    chk("simul_valid_after", out_valid, 0);
    chk("simul_occ", occupancy, 0);
    chk("simul_err", err_protocol, 0);

    // Protocol errors
    accept(4'd12, 1);
    p1_done = 1'b1; p1_dseq = 4'd13;
    settle();
    chk("err_before", err_protocol, 0);
    step();
    p1_done = 1'b0;
    chk("err_mismatch", err_protocol, 1);
    step(); step();
    chk("err_sticky", err_protocol, 1);
    do_reset();
    exp_q.delete();
    chk("err_rst_clear", err_protocol, 0);
    chk("err_rst_occ", occupancy, 0);
    done(2, 4'd0);
    chk("err_p2_idle", err_protocol, 1);
    do_reset();
    chk("err_rst_clear2", err_protocol, 0);
    out_rd_done = 1'b1;
    step();
    out_rd_done = 1'b0;
    chk("err_rd_no_valid", err_protocol, 1);
    do_reset();
    chk("err_rst_clear3", err_protocol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
